// File: rtl/draw_sprite.sv
// draw_sprite: 4-stage sprite overlay; generates the ROM address and merges the ROM colour over the background.
module draw_sprite #(
  parameter int WIDTH = 100,
  parameter int HEIGHT = 100,
  parameter logic [11:0] TRANSPARENT = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [13:0] pixel_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  logic        vblnk_q;
  logic [11:0] xpos_q, ypos_q;
  logic [37:0] d1, d2, d3;
  logic        hit1, hit2, hit3;
  logic [6:0]  rel_x, rel_y;
  logic [12:0] hc, vc, x0, y0, dx, dy;
  logic        hit_c;
  // 13-bit compares keep xpos_q+WIDTH from wrapping
  assign hc = {2'b0, hcount_in};
  assign vc = {2'b0, vcount_in};
  assign x0 = {1'b0, xpos_q};
  assign y0 = {1'b0, ypos_q};
  assign dx = hc - x0;
  assign dy = vc - y0;
  assign hit_c = !hblnk_in && !vblnk_in && hc >= x0 && hc < x0 + 13'(WIDTH)
                 && vc >= y0 && vc < y0 + 13'(HEIGHT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q    <= 1'b0;
      xpos_q     <= '0;
      ypos_q     <= '0;
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
      hit1       <= 1'b0;
      hit2       <= 1'b0;
      hit3       <= 1'b0;
      rel_x      <= '0;
      rel_y      <= '0;
      pixel_addr <= '0;
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      vblnk_q <= vblnk_in;
      if (vblnk_in && !vblnk_q) begin
        xpos_q <= xpos;
        ypos_q <= ypos;
      end
      d1    <= {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in};
      hit1  <= hit_c;
      rel_x <= dx[6:0];
      rel_y <= dy[6:0];
      d2         <= d1;
      hit2       <= hit1;
      pixel_addr <= hit1 ? 14'(rel_y) * 14'(WIDTH) + 14'(rel_x) : '0;
      d3   <= d2;
      hit3 <= hit2;
      {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} <= d3[37:12];
      rgb_out <= (hit3 && rom_rgb != TRANSPARENT) ? rom_rgb : d3[11:0];
    end
  end
endmodule

// File: tb/tb_draw_sprite.sv
// tb_draw_sprite: directed vectors for address generation, merge, frame latch and reset of draw_sprite.
module tb_draw_sprite;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, hblnk_in = 1'b1, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0, xpos = '0, ypos = '0;
  logic [13:0] pixel_addr;
  logic [11:0] rom_rgb = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  int checks = 0, errors = 0;

  draw_sprite dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .pixel_addr(pixel_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Registered ROM model: 1050 -> green, 1051 -> transparent, else {1, addr[10:0]}
  always @(posedge clk)
    rom_rgb <= (pixel_addr == 14'd1050) ? 12'h0F0 :
               (pixel_addr == 14'd1051) ? 12'h000 : (pixel_addr[11:0] | 12'h800);

  typedef struct {
    string       nm;
    logic [10:0] hc, vc;
    logic        hb, vb;
    logic [11:0] rgb;
    logic [13:0] ea;
    logic [11:0] er;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    hcount_in = '0; vcount_in = '0; hblnk_in = 1'b1; vblnk_in = 1'b0; rgb_in = 12'h000;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    hcount_in = v.hc; vcount_in = v.vc; hblnk_in = v.hb; vblnk_in = v.vb; rgb_in = v.rgb;
    @(negedge clk);
    idle();
    @(negedge clk);
    chk({v.nm, " addr"}, 32'(pixel_addr), 32'(v.ea));
    @(negedge clk);
    @(negedge clk);
    chk({v.nm, " rgb"}, 32'(rgb_out), 32'(v.er));
    chk({v.nm, " hcount"}, 32'(hcount_out), 32'(v.hc));
    chk({v.nm, " vcount"}, 32'(vcount_out), 32'(v.vc));
  endtask

  task automatic latch(input logic [11:0] x, input logic [11:0] y);
    @(negedge clk);
    xpos = x; ypos = y; vblnk_in = 1'b1; hblnk_in = 1'b1;
    @(negedge clk);
    idle();
  endtask

  initial begin
    tbl[0] = '{"hit_mid",    11'd250, 11'd160, 1'b0, 1'b0, 12'hABC, 14'd1050, 12'h0F0};
    tbl[1] = '{"transp",     11'd251, 11'd160, 1'b0, 1'b0, 12'hABC, 14'd1051, 12'hABC};
    tbl[2] = '{"top_left",   11'd200, 11'd150, 1'b0, 1'b0, 12'h111, 14'd0,    12'h800};
    tbl[3] = '{"bot_right",  11'd299, 11'd249, 1'b0, 1'b0, 12'h222, 14'd9999, 12'hF0F};
    tbl[4] = '{"x_past",     11'd300, 11'd150, 1'b0, 1'b0, 12'h333, 14'd0,    12'h333};
    tbl[5] = '{"y_past",     11'd200, 11'd250, 1'b0, 1'b0, 12'h444, 14'd0,    12'h444};
    tbl[6] = '{"x_before",   11'd199, 11'd150, 1'b0, 1'b0, 12'h555, 14'd0,    12'h555};
    tbl[7] = '{"hblank",     11'd250, 11'd160, 1'b1, 1'b0, 12'h666, 14'd0,    12'h666};
    tbl[8] = '{"vblank",     11'd250, 11'd160, 1'b0, 1'b1, 12'h777, 14'd0,    12'h777};
    // Reset held with toggling inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hcount_in = 11'($urandom); vcount_in = 11'($urandom); rgb_in = 12'($urandom);
      hblnk_in = 1'($urandom); vblnk_in = 1'($urandom); hsync_in = 1'b1; vsync_in = 1'b1;
      xpos = 12'd10; ypos = 12'd10;
      #1;
      chk("rst rgb", 32'(rgb_out), 0);
      chk("rst addr", 32'(pixel_addr), 0);
      chk("rst timing", 32'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}), 0);
    end
    // Release: hcount_out follows hcount_in 4 cycles later, zeros before that
    @(negedge clk);
    idle(); hsync_in = 1'b0; vsync_in = 1'b0;
    rst_n = 1'b1;
    hcount_in = 11'd10;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("release hcount", 32'(hcount_out), k >= 4 ? 32'(10 + k - 4) : 0);
      hcount_in = 11'(10 + k);
    end
    idle();
    latch(12'd200, 12'd150);
    for (int i = 0; i < 9; i++) apply(tbl[i]);
    // Mid-frame position change must not take effect
    @(negedge clk);
    xpos = 12'd400;
    apply('{"no_tear", 11'd250, 11'd160, 1'b0, 1'b0, 12'hABC, 14'd1050, 12'h0F0});
    latch(12'd400, 12'd150);
    apply('{"new_pos", 11'd400, 11'd160, 1'b0, 1'b0, 12'h9AB, 14'd1000, 12'hBE8});
    apply('{"old_pos", 11'd250, 11'd160, 1'b0, 1'b0, 12'h9AB, 14'd0,    12'h9AB});
    // Sprite hanging off the right edge of a 1024-wide line
    latch(12'd1000, 12'd150);
    apply('{"edge_hit",  11'd1023, 11'd160, 1'b0, 1'b0, 12'h123, 14'd1023, 12'hBFF});
    apply('{"edge_miss", 11'd999,  11'd160, 1'b0, 1'b0, 12'h123, 14'd0,    12'h123});
    latch(12'd1100, 12'd150);
    apply('{"far_x", 11'd1023, 11'd160, 1'b0, 1'b0, 12'h456, 14'd0, 12'h456});
    // Reset mid-line clears the pipeline
    latch(12'd200, 12'd150);
    @(negedge clk);
    hcount_in = 11'd250; vcount_in = 11'd160; hblnk_in = 1'b0; rgb_in = 12'hABC;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst addr", 32'(pixel_addr), 0);
    chk("midrst hcount", 32'(hcount_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    latch(12'd200, 12'd150);
    apply('{"post_rst", 11'd250, 11'd160, 1'b0, 1'b0, 12'hABC, 14'd1050, 12'h0F0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
